// File: rtl/led_scan_scheduler.sv
// Round-robin LED matrix scan scheduler: grants one pixel source at a time and drives LEDout for a dwell, then blanks.
// Optional macro LED_SCAN_PRIO_EN gives source 0 fixed top priority over the round-robin sources.
module led_scan_scheduler #(
    parameter int NUM_SRC   = 4,
    parameter int DWELL     = 2000,
    parameter int BLANK_CYC = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   enable,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [3*NUM_SRC-1:0]   src_x,
    input  logic [4*NUM_SRC-1:0]   src_y,
    input  logic [2*NUM_SRC-1:0]   src_color,
    output logic [NUM_SRC-1:0]     src_ready,
    output logic [9:0]             LEDout,
    output logic [2:0]             grant_id,
    output logic                   busy,
    output logic                   scan_wrap
);

    // state | meaning
    // IDLE  | arbitrate; grant the first valid source from rr_ptr onward
    // SHOW  | drive the latched pixel for DWELL cycles
    // BLANK | force LEDout dark for BLANK_CYC cycles
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHOW  = 2'd1;
    localparam logic [1:0] S_BLANK = 2'd2;

    localparam int CNT_MAX = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int PW      = $clog2(NUM_SRC);

    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [9:0]    led_q, led_d;
    logic [PW-1:0] grant_q, grant_d;
    logic [PW-1:0] rr_q, rr_d;
    logic          wrap_q, wrap_d;

    logic          win_found;
    logic [PW-1:0] win_idx;
    logic          prio_hit;
    logic [PW:0]   scan_sum;
    logic [9:0]    win_pix;
    logic          grant;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan_sum  = '0;
        prio_hit  = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_sum = {1'b0, rr_q} + (PW+1)'(k);
            if (scan_sum >= (PW+1)'(NUM_SRC)) begin
                scan_sum = scan_sum - (PW+1)'(NUM_SRC);
            end
            if (!win_found && src_valid[scan_sum[PW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan_sum[PW-1:0];
            end
        end
`ifdef LED_SCAN_PRIO_EN
        // Source 0 preempts the rotation and leaves rr_ptr untouched.
        if (src_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
            prio_hit  = 1'b1;
        end
`endif
    end

    always_comb begin
        win_pix = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (win_idx == PW'(i)) begin
                win_pix = {src_color[2*i +: 2], 1'b0, src_y[4*i +: 4], src_x[3*i +: 3]};
            end
        end
    end

    // Ready is held off during reset so a source never sees an accept that gets discarded.
    assign grant     = (state_q == S_IDLE) && enable && win_found && !RST;
    assign src_ready = grant ? (NUM_SRC'(1) << win_idx) : '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        led_d   = led_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        wrap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                led_d = '0;
                if (grant) begin
                    state_d = S_SHOW;
                    led_d   = win_pix;
                    grant_d = win_idx;
                    cnt_d   = DWELL_LD;
                    if (!prio_hit) begin
                        rr_d = (win_idx == PW'(NUM_SRC - 1)) ? '0 : win_idx + 1'b1;
                    end
                    wrap_d = (win_idx == PW'(NUM_SRC - 1));
                end
            end
            S_SHOW: begin
                if (cnt_q == '0) begin
                    led_d = '0;
                    if (BLANK_CYC > 0) begin
                        state_d = S_BLANK;
                        cnt_d   = BLANK_LD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_BLANK: begin
                led_d = '0;
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                led_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            led_q   <= '0;
            grant_q <= '0;
            rr_q    <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            wrap_q  <= wrap_d;
        end
    end

    assign LEDout    = led_q;
    assign grant_id  = 3'(grant_q);
    assign busy      = (state_q != S_IDLE);
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Directed bench for led_scan_scheduler: one instance with a blank phase, one without.
// Build with LED_SCAN_PRIO_EN defined to exercise the fixed-priority variant.
module tb_led_scan_scheduler;

    logic        CLK = 1'b0;
    logic        RST;
    logic        enable;
    logic [3:0]  src_valid;
    logic [11:0] src_x;
    logic [15:0] src_y;
    logic [7:0]  src_color;

    logic [3:0]  a_ready, b_ready;
    logic [9:0]  a_led, b_led;
    logic [2:0]  a_gid, b_gid;
    logic        a_busy, b_busy;
    logic        a_wrap, b_wrap;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [9:0] L1 = 10'b1000110010;
    localparam logic [9:0] L2 = 10'b0101100101;
    localparam logic [9:0] L3 = 10'b1101111111;

    always #5 CLK = ~CLK;

    led_scan_scheduler #(.NUM_SRC(4), .DWELL(4), .BLANK_CYC(1)) dut_a (
        .CLK(CLK), .RST(RST), .enable(enable), .src_valid(src_valid),
        .src_x(src_x), .src_y(src_y), .src_color(src_color),
        .src_ready(a_ready), .LEDout(a_led), .grant_id(a_gid),
        .busy(a_busy), .scan_wrap(a_wrap)
    );

    led_scan_scheduler #(.NUM_SRC(4), .DWELL(4), .BLANK_CYC(0)) dut_b (
        .CLK(CLK), .RST(RST), .enable(enable), .src_valid(src_valid),
        .src_x(src_x), .src_y(src_y), .src_color(src_color),
        .src_ready(b_ready), .LEDout(b_led), .grant_id(b_gid),
        .busy(b_busy), .scan_wrap(b_wrap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        logic [3:0] exp_rdy;
        RST       = 1'b1;
        enable    = 1'b0;
        src_valid = 4'b0000;
        src_x     = {3'd7, 3'd5, 3'd2, 3'd1};
        src_y     = {4'd15, 4'd12, 4'd6, 4'd3};
        src_color = {2'b11, 2'b01, 2'b10, 2'b11};
        step(); step();
        RST = 1'b0;
        #1;
        chk("rst_led",   32'(a_led),   32'd0);
        chk("rst_busy",  32'(a_busy),  32'd0);
        chk("rst_gid",   32'(a_gid),   32'd0);
        chk("rst_wrap",  32'(a_wrap),  32'd0);
        chk("rst_ready", 32'(a_ready), 32'd0);

        // Single source 2: latency, dwell, blank, regrant spacing
        step();
        enable    = 1'b1;
        src_valid = 4'b0100;
        #1;
        chk("t1_accept", 32'(a_ready), 32'h4);
        for (int i = 1; i <= 4; i++) begin
            step(); #1;
            chk("t1_led",   32'(a_led),   32'(L2));
            chk("t1_busy",  32'(a_busy),  32'd1);
            chk("t1_gid",   32'(a_gid),   32'd2);
            chk("t1_ready", 32'(a_ready), 32'd0);
        end
        step(); #1;
        chk("t1_blank_led",   32'(a_led),   32'd0);
        chk("t1_blank_busy",  32'(a_busy),  32'd1);
        chk("t1_blank_ready", 32'(a_ready), 32'd0);
        step(); #1;
        chk("t1_regrant", 32'(a_ready), 32'h4);

        // Reset in the middle of SHOW
        step(); step();
        RST = 1'b1;
        #1;
        chk("t1_pre_rst_led", 32'(a_led), 32'(L2));
        step(); #1;
        chk("t1_rst_led",   32'(a_led),   32'd0);
        chk("t1_rst_busy",  32'(a_busy),  32'd0);
        chk("t1_rst_ready", 32'(a_ready), 32'd0);
        RST       = 1'b0;
        src_valid = 4'b1111;
        #1;
        chk("t1_rr_zero", 32'(a_ready), 32'h1);

`ifndef LED_SCAN_PRIO_EN
        // All valid: rotation 0,1,2,3,0,1 every 6 cycles, one wrap after source 3
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) begin
                step(); #1;
            end
            exp_rdy = (c % 6 == 0) ? 4'(1 << ((c / 6) % 4)) : 4'b0000;
            chk("t2_ready", 32'(a_ready), 32'(exp_rdy));
            chk("t2_wrap",  32'(a_wrap),  (c == 19) ? 32'd1 : 32'd0);
        end
        // Drop enable while source 1 is shown
        step();
        enable = 1'b0;
        #1;
        chk("t3_gid", 32'(a_gid), 32'd1);
        for (int c = 31; c <= 39; c++) begin
            if (c > 31) begin
                step(); #1;
            end
            chk("t3_led",   32'(a_led),   (c <= 34) ? 32'(L1) : 32'd0);
            chk("t3_ready", 32'(a_ready), 32'd0);
            if (c >= 36) chk("t3_idle", 32'(a_busy), 32'd0);
        end
        step();
        enable = 1'b1;
        #1;
        chk("t3_resume", 32'(a_ready), 32'h4);
`else
        // Source 0 always wins while valid; then 1,2,3 from an untouched rr_ptr
        for (int c = 0; c <= 30; c++) begin
            if (c > 0) begin
                step();
                if (c == 18) src_valid = 4'b1110;
                #1;
            end
            if (c < 18) exp_rdy = (c % 6 == 0) ? 4'b0001 : 4'b0000;
            else        exp_rdy = (c % 6 == 0) ? 4'(1 << ((c - 18) / 6 + 1)) : 4'b0000;
            chk("tp_ready", 32'(a_ready), 32'(exp_rdy));
        end
`endif

        // No blank phase: only source 3, regrant every 5 cycles
        step();
        RST       = 1'b1;
        src_valid = 4'b1000;
        step(); step();
        RST = 1'b0;
        for (int c = 0; c <= 14; c++) begin
            if (c > 0) step();
            #1;
            chk("t4_ready", 32'(b_ready), (c % 5 == 0) ? 32'h8 : 32'h0);
            chk("t4_led",   32'(b_led),   (c % 5 == 0) ? 32'd0 : 32'(L3));
        end

        // Source data changes after accept do not disturb the shown pixel
        step();
        RST = 1'b1;
        step(); step();
        RST       = 1'b0;
        src_valid = 4'b0010;
        #1;
        chk("t5_accept", 32'(a_ready), 32'h2);
        step();
        src_valid  = 4'b0000;
        src_x[5:3] = 3'd0;
        #1;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) begin
                step(); #1;
            end
            chk("t5_led",   32'(a_led),   32'(L1));
            chk("t5_ready", 32'(a_ready), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/led_scan_scheduler.md
Name: led_scan_scheduler

Overview:
Time-multiplexes the single 10-bit LED matrix drive word between several pixel sources: bar 1, bar 2, ball, and overlay/score sprite.
Each source presents one pixel at a time on a valid/ready handshake. The scheduler grants sources round-robin, holds the granted pixel on LEDout for a fixed dwell period, then blanks before the next grant.
It replaces the free-running slot-counter case decode in the game top level and sits between the game-object logic and the LEDout pins.

Parameters:
NUM_SRC, 4, number of pixel sources (2..8)
DWELL, 2000, cycles a granted pixel is driven on LEDout (>=1)
BLANK_CYC, 2, cycles LEDout forced to 0 after each dwell (0 allowed = no blank)

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
enable  in  1  scan enable; when low no new grants are issued
src_valid  in  NUM_SRC  per-source pixel valid
src_x  in  3*NUM_SRC  per-source column, source i at [3i+2:3i]
src_y  in  4*NUM_SRC  per-source row, source i at [4i+3:4i]
src_color  in  2*NUM_SRC  per-source colour, source i at [2i+1:2i]
src_ready  out  NUM_SRC  one-cycle accept pulse to the granted source
LEDout  out  10  {color[1:0], 1'b0, y[3:0], x[2:0]}; all-zero = dark
grant_id  out  3  index of source currently shown; valid while busy
busy  out  1  high in SHOW and BLANK
scan_wrap  out  1  one-cycle pulse when the round-robin pointer wraps past NUM_SRC-1

Behaviour:
- Reset (RST=1 at posedge): state IDLE, LEDout=0, src_ready=0, grant_id=0, busy=0, scan_wrap=0, rr_ptr=0, counter=0. A reset in any state aborts the pixel; LEDout is 0 on the next cycle.
- States: IDLE, SHOW, BLANK.
- IDLE, grant condition: enable=1 and any src_valid bit set.
  - Winner = first valid index scanning rr_ptr, rr_ptr+1, ... modulo NUM_SRC.
  - That cycle src_ready[winner] is asserted combinationally; it is the only ready bit high.
  - x, y and color of the winner are latched at that edge.
- IDLE, on the grant edge:
  - state <= SHOW, LEDout <= latched pixel, grant_id <= winner, counter <= DWELL-1.
  - rr_ptr <= (winner+1) mod NUM_SRC.
  - scan_wrap pulses on the next cycle iff winner+1 == NUM_SRC.
- IDLE with no grant: LEDout=0, src_ready=0.
- Latency: the accept cycle is N, and the pixel appears on LEDout at N+1 for exactly DWELL cycles.
- SHOW: counter decrements each cycle. At counter==0:
  - BLANK_CYC>0: state <= BLANK, LEDout <= 0, counter <= BLANK_CYC-1.
  - BLANK_CYC==0: state <= IDLE, LEDout <= 0.
- BLANK: LEDout=0, counter decrements; at 0, state <= IDLE.
- Pixel period: 1 + DWELL + BLANK_CYC cycles per grant (IDLE arbitration cycle included).
- Starvation bound: a continuously valid source waits at most NUM_SRC-1 pixel periods.
- enable falling in SHOW/BLANK: current pixel and blank complete normally, then the block stays in IDLE until enable=1.
- Source changes after accept: a source dropping src_valid or changing x/y/color after accept does not affect the displayed pixel (data is latched).
- Ready handshake: src_ready is never asserted outside IDLE and never to a source with src_valid=0.
- Counter widths: width sized to max(DWELL, BLANK_CYC); no wrap beyond loaded value.

Optional Feature:
LED_SCAN_PRIO_EN
- Defined: source 0 (ball) has fixed top priority. If src_valid[0]=1 in IDLE it wins regardless of rr_ptr, and rr_ptr is not updated by that grant. Other sources remain round-robin among themselves.
- Undefined: pure round-robin as above.

Test Plan:
- Reset mid-SHOW: NUM_SRC=4, DWELL=4, BLANK_CYC=1; src 2 valid, x=5, y=12, color=2'b01. Expect:
  - src_ready[2] pulse at cycle N.
  - LEDout=10'b0101100101 for cycles N+1..N+4, then 0 at N+5.
  - Next grant no earlier than N+6.
  - Reset raised at N+2 gives LEDout=0 at N+3, busy=0 and rr_ptr=0.
- All four valid, held: grants in order 0,1,2,3,0 at 6-cycle spacing; scan_wrap pulses once, on the cycle after source 3's accept.
- enable dropped during SHOW of source 1: pixel completes its 4 cycles plus blank; no src_ready until enable returns; next grant is source 2.
- BLANK_CYC=0, only src 3 valid: back-to-back grants every 5 cycles; LEDout is 0 only on the IDLE cycle between them.
- src_valid[1] deasserted and x changed on the cycle after accept: LEDout keeps the latched pixel for the full DWELL.
- LED_SCAN_PRIO_EN defined, all valid: source 0 wins every grant; sources 1–3 never granted until src_valid[0]=0, then 1,2,3 in order.
